// File: rtl/im_port_arbiter_pkg.sv
// Shared sizing for the instruction-memory port arbiter: core count, widths
// and the grant-index width helper.
package im_port_arbiter_pkg;

  localparam int NUM_C  = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // A single-core build still needs a 1-bit index and pointer.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(NUM_C);

endpackage

// File: rtl/im_port_arbiter_if.sv
// Core-side fetch bus and memory-side read port of the instruction arbiter.
interface im_port_arbiter_if;
  import im_port_arbiter_pkg::*;

  logic [NUM_C-1:0]        req;
  logic [NUM_C-1:0]        halt;
  logic [NUM_C*ADDR_W-1:0] addr;
  logic [NUM_C-1:0]        gnt;
  logic [NUM_C-1:0]        rvalid;
  logic [NUM_C*DATA_W-1:0] data_out;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_rdata;
  logic [15:0]             busy_cnt;

  modport slave (
    input  req, halt, addr, mem_rdata,
    output gnt, rvalid, data_out, mem_en, mem_addr, busy_cnt
  );

  modport master (
    output req, halt, addr, mem_rdata,
    input  gnt, rvalid, data_out, mem_en, mem_addr, busy_cnt
  );

endinterface

// File: rtl/im_port_arbiter_rr_pick.sv
// Combinational round-robin one-hot selector: searches from ptr+1 upward,
// wrapping, and picks the first eligible requester.
module im_port_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    // ptr itself is visited last, so a lone requester is granted every cycle.
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && eligible[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/im_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read instruction RAM between
// NUM_C cores, with per-core registered return data and a contention counter.
module im_port_arbiter
  import im_port_arbiter_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  im_port_arbiter_if.slave  bus
);

  logic [NUM_C-1:0]        eligible;
  logic [NUM_C-1:0]        gnt;
  logic [IDX_W-1:0]        idx;
  logic                    any;
  logic [IDX_W-1:0]        ptr;
  logic                    pend_v;
  logic [IDX_W-1:0]        pend_id;
  logic [NUM_C-1:0]        rvalid;
  logic [NUM_C*DATA_W-1:0] data_out;
  logic [15:0]             busy_cnt;
  logic                    contend;

  // Gating with rst_n keeps gnt and mem_en quiet while reset is held.
  assign eligible = rst_n ? (bus.req & ~bus.halt) : '0;
  assign contend  = |(eligible & (eligible - NUM_C'(1)));

  im_port_arbiter_rr_pick #(
    .N  (NUM_C),
    .IW (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .gnt      (gnt),
    .idx      (idx),
    .any      (any)
  );

  assign bus.gnt      = gnt;
  assign bus.mem_en   = any;
  assign bus.mem_addr = any ? bus.addr[int'(idx)*ADDR_W +: ADDR_W] : '0;
  assign bus.rvalid   = rvalid;
  assign bus.data_out = data_out;
  assign bus.busy_cnt = busy_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= IDX_W'(NUM_C - 1);
      pend_v   <= 1'b0;
      pend_id  <= '0;
      rvalid   <= '0;
      data_out <= '0;
      busy_cnt <= '0;
    end else begin
      if (any) begin
        ptr <= idx;
      end
      pend_v  <= any;
      pend_id <= idx;
      rvalid  <= pend_v ? (NUM_C'(1) << pend_id) : '0;
      // mem_rdata is only trusted in the cycle after a read was issued.
      if (pend_v) begin
        data_out[int'(pend_id)*DATA_W +: DATA_W] <= bus.mem_rdata;
      end
      if (contend && (busy_cnt != 16'hFFFF)) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Bench for im_port_arbiter: vector table plus hand sequences, with a
// scoreboard checking grants, read returns, hold registers and busy_cnt.
module tb_im_port_arbiter;
  import im_port_arbiter_pkg::*;

  typedef struct {
    logic [NUM_C-1:0] req;
    logic [NUM_C-1:0] halt;
    logic [NUM_C-1:0] gnt;
  } vec_t;

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  im_port_arbiter_if bus ();

  im_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return 16'(a * 16'd5 + 16'd2);
  endfunction

  // Synchronous-read RAM; idle cycles return junk that must never be latched.
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= mem_fn(bus.mem_addr);
    else            bus.mem_rdata <= 16'hDEAD;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [ADDR_W-1:0] a [NUM_C];

  task automatic set_bus(input logic [NUM_C-1:0] r, input logic [NUM_C-1:0] h);
    bus.req  = r;
    bus.halt = h;
    for (int i = 0; i < NUM_C; i++) bus.addr[i*ADDR_W +: ADDR_W] = a[i];
  endtask

  task automatic drive(input logic [NUM_C-1:0] r, input logic [NUM_C-1:0] h, input int k);
    for (int i = 0; i < NUM_C; i++) a[i] = 16'(i * 16'h1000 + k * 8 + 1);
    set_bus(r, h);
  endtask

  // ---------------- reference model + scoreboard ----------------
  exp_t             q[$];
  exp_t             e;
  int               mptr = NUM_C - 1;
  int               bm = 0;
  logic             nxt_g = 1'b0;
  int               nxt_idx = 0;
  logic             nxt_busy = 1'b0;
  logic [15:0]      md [NUM_C];
  logic [NUM_C-1:0] elig;
  logic [NUM_C-1:0] egnt;
  int               eidx;
  int               ecnt;
  logic [NUM_C*DATA_W-1:0] exp_do;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr     = NUM_C - 1;
      bm       = 0;
      nxt_g    = 1'b0;
      nxt_busy = 1'b0;
      for (int i = 0; i < NUM_C; i++) md[i] = '0;
      check("rst_gnt", 64'(bus.gnt), 64'd0);
      check("rst_mem_en", 64'(bus.mem_en), 64'd0);
      check("rst_rvalid", 64'(bus.rvalid), 64'd0);
      check("rst_data_out", 64'(bus.data_out), 64'd0);
      check("rst_busy", 64'(bus.busy_cnt), 64'd0);
    end else begin
      elig = bus.req & ~bus.halt;
      egnt = '0;
      eidx = 0;
      ecnt = 0;
      for (int k = 1; k <= NUM_C; k++) begin
        int j;
        j = (mptr + k) % NUM_C;
        if (egnt == '0 && elig[j]) begin
          egnt[j] = 1'b1;
          eidx    = j;
        end
      end
      for (int i = 0; i < NUM_C; i++) if (elig[i]) ecnt++;
      check("gnt", 64'(bus.gnt), 64'(egnt));
      check("mem_en", 64'(bus.mem_en), 64'(egnt != '0));
      check("mem_addr", 64'(bus.mem_addr), (egnt != '0) ? 64'(a[eidx]) : 64'd0);
      nxt_g    = (egnt != '0);
      nxt_idx  = eidx;
      nxt_busy = (ecnt >= 2);
      if (nxt_g) begin
        e.due  = cyc + 2;
        e.id   = eidx;
        e.data = mem_fn(a[eidx]);
        q.push_back(e);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("rvalid", 64'(bus.rvalid), 64'(NUM_C'(1) << e.id));
        md[e.id] = e.data;
      end else begin
        check("rvalid_idle", 64'(bus.rvalid), 64'd0);
      end
      for (int i = 0; i < NUM_C; i++) exp_do[i*DATA_W +: DATA_W] = md[i];
      check("data_out", 64'(bus.data_out), 64'(exp_do));
      check("busy_cnt", 64'(bus.busy_cnt), 64'(bm));
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (nxt_g) mptr = nxt_idx;
      if (nxt_busy && bm != 16'hFFFF) bm++;
    end
  end

  // ---------------- stimulus ----------------
  vec_t tbl [16];

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 4'b0000, 4'(1 << (i % 4))};
    for (int i = 8; i < 13; i++) tbl[i] = '{4'b0100, 4'b0000, 4'b0100};
    tbl[13] = '{4'b1010, 4'b0010, 4'b1000};
    tbl[14] = '{4'b1010, 4'b1010, 4'b0000};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000};

    // Reset release with a request already waiting
    rst_n = 1'b0;
    for (int i = 0; i < NUM_C; i++) a[i] = '0;
    a[0] = 16'd5;
    set_bus(4'b0001, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t1_gnt", 64'(bus.gnt), 64'b0001);
    check("t1_mem_addr", 64'(bus.mem_addr), 64'd5);
    @(posedge clk);
    #1 set_bus(4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_data_out", 64'(bus.data_out), 64'd27);

    // Table: full contention, lone requester, halt masking
    @(posedge clk);
    #1 do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].req, tbl[k].halt, k);
      @(negedge clk);
      check($sformatf("tbl%0d_gnt", k), 64'(bus.gnt), 64'(tbl[k].gnt));
      @(posedge clk);
      #1;
    end
    drive('0, '0, 50);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t2_busy8", 64'(bus.busy_cnt), 64'd8);

    // Reset in the cycle after a grant discards the read; ptr restarts
    @(posedge clk);
    #1 drive(4'b0001, 4'b0000, 100);
    @(negedge clk);
    check("t5_gnt0", 64'(bus.gnt), 64'b0001);
    @(posedge clk);
    #1 rst_n = 1'b0;
    drive('0, '0, 101);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_data_clr", 64'(bus.data_out), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(4'b0011, 4'b0000, 102);
    @(negedge clk);
    check("t5_first_gnt", 64'(bus.gnt), 64'b0001);
    @(posedge clk);
    #1 drive('0, '0, 103);
    repeat (4) @(posedge clk);

    // busy_cnt saturation under sustained contention
    #1 do_reset();
    drive(4'b1111, 4'b0000, 200);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("t6_fffe", 64'(bus.busy_cnt), 64'hFFFE);
    @(posedge clk);
    @(negedge clk);
    check("t6_ffff", 64'(bus.busy_cnt), 64'hFFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_hold", 64'(bus.busy_cnt), 64'hFFFF);
    @(posedge clk);
    #1 drive('0, '0, 201);
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
